// File: rtl/poly_axis_line_writer.sv
// poly_axis_line_writer
// Packs LINE_W-bit AXI-stream beats into even/odd line-pair writes for the
// dual-port write side of the input poly FIFO. One polynomial is framed by
// wr_finish: it drops when the first FILL cycle begins and rises again in
// FLUSH, after the final pair write, so the FIFO commits the polynomial.
module poly_axis_line_writer #(
    parameter int LINE_W     = 512,
    parameter int ADDR_W     = 9,
    parameter int POLY_LINES = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err_last,
    input  logic [LINE_W-1:0] s_tdata,
    input  logic              s_tvalid,
    input  logic              s_tlast,
    output logic              s_tready,
    input  logic              fifo_full,
    output logic              wr_finish,
    output logic              wr_enable,
    output logic [ADDR_W-1:0] addrA,
    output logic [ADDR_W-1:0] addrB,
    output logic [LINE_W-1:0] dA,
    output logic [LINE_W-1:0] dB
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_FILL,
        S_FLUSH
    } state_t;

    localparam logic [ADDR_W:0] LAST_BEAT = (ADDR_W+1)'(POLY_LINES - 1);
    localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W+1)'(1);

    state_t              state_reg;
    logic [ADDR_W:0]     beat_cnt_reg;
    logic [LINE_W-1:0]   hold_reg;
    logic                busy_reg;
    logic                done_reg;
    logic                err_last_reg;
    logic                s_tready_reg;
    logic                wr_finish_reg;
    logic                wr_enable_reg;
    logic [ADDR_W-1:0]   addr_a_reg;
    logic [ADDR_W-1:0]   addr_b_reg;
    logic [LINE_W-1:0]   d_a_reg;
    logic [LINE_W-1:0]   d_b_reg;

    logic beat_fire;
    logic is_last_beat;

    // A beat is consumed only in FILL while the registered ready is high.
    assign beat_fire    = (state_reg == S_FILL) && s_tvalid && s_tready_reg;
    assign is_last_beat = (beat_cnt_reg == LAST_BEAT);

    // Control FSM, beat counter, hold register and registered write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            beat_cnt_reg  <= '0;
            hold_reg      <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_last_reg  <= 1'b0;
            s_tready_reg  <= 1'b0;
            wr_finish_reg <= 1'b1;
            wr_enable_reg <= 1'b0;
            addr_a_reg    <= '0;
            addr_b_reg    <= '0;
            d_a_reg       <= '0;
            d_b_reg       <= '0;
        end else begin
            // Strobes default low; address/data simply hold between writes.
            wr_enable_reg <= 1'b0;
            done_reg      <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        busy_reg     <= 1'b1;
                        err_last_reg <= 1'b0;
                        if (fifo_full) begin
                            state_reg <= S_WAIT;
                        end else begin
                            state_reg     <= S_FILL;
                            wr_finish_reg <= 1'b0;
                            s_tready_reg  <= 1'b1;
                            beat_cnt_reg  <= '0;
                        end
                    end
                end
                S_WAIT: begin
                    if (!fifo_full) begin
                        state_reg     <= S_FILL;
                        wr_finish_reg <= 1'b0;
                        s_tready_reg  <= 1'b1;
                        beat_cnt_reg  <= '0;
                    end
                end
                S_FILL: begin
                    if (beat_fire) begin
                        // tlast is only checked, never obeyed: the beat count ends the poly.
                        if (s_tlast != is_last_beat) begin
                            err_last_reg <= 1'b1;
                        end
                        beat_cnt_reg <= beat_cnt_reg + CNT_ONE;
                        if (!beat_cnt_reg[0]) begin
                            hold_reg <= s_tdata;
                        end else begin
                            wr_enable_reg <= 1'b1;
                            addr_a_reg    <= {beat_cnt_reg[ADDR_W-1:1], 1'b0};
                            addr_b_reg    <= beat_cnt_reg[ADDR_W-1:0];
                            d_a_reg       <= hold_reg;
                            d_b_reg       <= s_tdata;
                        end
                        // Stop taking beats once the final one is in; the last
                        // pair write goes out in the following cycle.
                        if (is_last_beat) begin
                            s_tready_reg <= 1'b0;
                        end
                    end else if (!s_tready_reg) begin
                        // Ready is only low in FILL during the last pair write.
                        state_reg     <= S_FLUSH;
                        wr_finish_reg <= 1'b1;
                        done_reg      <= 1'b1;
                    end
                end
                S_FLUSH: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign err_last  = err_last_reg;
    assign s_tready  = s_tready_reg;
    assign wr_finish = wr_finish_reg;
    assign wr_enable = wr_enable_reg;
    assign addrA     = addr_a_reg;
    assign addrB     = addr_b_reg;
    assign dA        = d_a_reg;
    assign dB        = d_b_reg;

endmodule

// File: tb/tb_poly_axis_line_writer.sv
// Testbench for poly_axis_line_writer: table of polynomial scenarios plus
// hand-written reset-abort and back-to-back sequences. Expected pair writes
// are queued as odd beats are accepted and popped when wr_enable fires.
module tb_poly_axis_line_writer;

    localparam int LW = 32;
    localparam int AW = 4;
    localparam int PL = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic          err_last;
    logic [LW-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tlast;
    logic          s_tready;
    logic          fifo_full;
    logic          wr_finish;
    logic          wr_enable;
    logic [AW-1:0] addrA;
    logic [AW-1:0] addrB;
    logic [LW-1:0] dA;
    logic [LW-1:0] dB;

    always #5 clk = ~clk;

    poly_axis_line_writer #(
        .LINE_W    (LW),
        .ADDR_W    (AW),
        .POLY_LINES(PL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .err_last (err_last),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .s_tlast  (s_tlast),
        .s_tready (s_tready),
        .fifo_full(fifo_full),
        .wr_finish(wr_finish),
        .wr_enable(wr_enable),
        .addrA    (addrA),
        .addrB    (addrB),
        .dA       (dA),
        .dB       (dB)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [AW-1:0] b;
        logic [LW-1:0] da;
        logic [LW-1:0] db;
    } wr_t;

    typedef struct {
        int            full_cycles;
        bit            gaps;
        int            bad_tlast;
        bit            omit_last;
        bit            poke_start;
        logic [LW-1:0] base;
        bit            exp_err;
    } vec_t;

    wr_t           exp_q[$];
    int            pass_cnt    = 0;
    int            check_cnt   = 0;
    int            odd_acc_cnt = 0;
    int            done_cnt    = 0;
    int            wr_ptr      = 0;
    logic [LW-1:0] fifo_mem [4][PL];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        check_cnt++;
        $display("FAIL %s: got no event, required event within bound", name);
    endtask

    // Monitor: write timing, scoreboard pop, done count and depth-4 FIFO model.
    initial begin : monitor
        int  seen;
        bit  prev_wf;
        wr_t w;
        seen    = 0;
        prev_wf = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                wr_ptr  = 0;
                prev_wf = 1'b1;
                seen    = odd_acc_cnt;
                exp_q.delete();
                continue;
            end
            if ((odd_acc_cnt != seen) || wr_enable) begin
                check("wr_enable_timing", 128'(wr_enable), 128'(odd_acc_cnt != seen));
                seen = odd_acc_cnt;
            end
            if (wr_enable) begin
                if (exp_q.size() == 0) begin
                    fail_now("write_unexpected");
                end else begin
                    w = exp_q.pop_front();
                    $display("write A=%0d B=%0d dA=%0h dB=%0h", addrA, addrB, dA, dB);
                    check("pair_write", 128'({addrA, addrB, dA, dB}), 128'(w));
                end
                check("wr_finish_low_on_write", 128'(wr_finish), 128'(0));
                fifo_mem[wr_ptr % 4][addrA] = dA;
                fifo_mem[wr_ptr % 4][addrB] = dB;
            end
            if (done) done_cnt++;
            if (wr_finish && !prev_wf) wr_ptr++;
            prev_wf = wr_finish;
        end
    end

    task automatic send_beat(input int idx, input logic [LW-1:0] base, input bit last, output bit ok);
        int  n;
        wr_t w;
        n        = 0;
        s_tdata  = base + LW'(idx);
        s_tlast  = last;
        s_tvalid = 1'b1;
        while (!s_tready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        ok = s_tready;
        if (!ok) begin
            fail_now("handshake_timeout");
            return;
        end
        @(posedge clk); #1;
        if (idx % 2 == 1) begin
            w.a  = AW'(idx - 1);
            w.b  = AW'(idx);
            w.da = base + LW'(idx - 1);
            w.db = base + LW'(idx);
            exp_q.push_back(w);
            odd_acc_cnt++;
        end
    endtask

    task automatic run_poly(input vec_t v);
        int n;
        int d0;
        bit ok;
        bit last;
        d0        = done_cnt;
        fifo_full = (v.full_cycles > 0);
        // Beat 0 is offered together with start; it must not be taken in IDLE.
        s_tdata   = v.base;
        s_tlast   = (v.bad_tlast == 0);
        s_tvalid  = 1'b1;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < v.full_cycles; k++) begin
            @(negedge clk);
            check("wait_state", 128'({s_tready, wr_finish, busy, wr_enable}), 128'(4'b0110));
            @(posedge clk); #1;
        end
        if (v.full_cycles > 0) begin
            fifo_full = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        check("fill_entry", 128'({wr_finish, s_tready, busy, err_last}), 128'(4'b0110));
        for (int i = 0; i < PL; i++) begin
            if (i > 0 && v.gaps) begin
                s_tvalid = 1'b0;
                repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
            end
            if (v.poke_start && i == 2) start = 1'b1;
            last = (i == v.bad_tlast) || (i == PL - 1 && !v.omit_last);
            send_beat(i, v.base, last, ok);
            start = 1'b0;
            if (!ok) return;
            if (i == v.bad_tlast) begin
                @(negedge clk);
                check("err_last_set", 128'(err_last), 128'(1));
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 20);
        check("done_cycle", 128'({done, wr_finish, s_tready, err_last}), 128'({3'b110, v.exp_err}));
        @(negedge clk);
        check("idle_after", 128'({done, busy}), 128'(2'b00));
        check("done_once", 128'(done_cnt - d0), 128'(1));
        check("queue_drained", 128'(exp_q.size()), 128'(0));
        $display("poly base=%0h done err_last=%0b", v.base, err_last);
    endtask

    initial begin : watchdog
        #200000;
        fail_now("global_timeout");
        $fatal(1, "simulation timeout");
    end

    initial begin : driver
        vec_t vecs[5];
        vec_t fresh;
        vec_t b2b0;
        vec_t b2b1;
        bit   ok;
        int   ptr0;

        //            full gaps bad omit poke base       err
        vecs[0] = '{0, 1'b0, -1, 1'b0, 1'b0, 32'h0,   1'b0};
        vecs[1] = '{5, 1'b0, -1, 1'b0, 1'b0, 32'h100, 1'b0};
        vecs[2] = '{0, 1'b1, -1, 1'b0, 1'b1, 32'h0,   1'b0};
        vecs[3] = '{0, 1'b0,  3, 1'b1, 1'b0, 32'h200, 1'b1};
        vecs[4] = '{0, 1'b1,  5, 1'b0, 1'b0, 32'h300, 1'b1};

        rst       = 1'b1;
        start     = 1'b0;
        s_tdata   = '0;
        s_tvalid  = 1'b0;
        s_tlast   = 1'b0;
        fifo_full = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl", 128'({wr_finish, busy, done, s_tready, wr_enable, err_last}), 128'(6'b100000));
        check("reset_data", 128'({addrA, addrB, dA, dB}), 128'(0));
        #1 rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) run_poly(vecs[i]);

        // Reset after beat 5: partial poly abandoned, fresh one starts at line 0.
        s_tdata  = 32'h700;
        s_tlast  = 1'b0;
        s_tvalid = 1'b1;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send_beat(i, 32'h700, 1'b0, ok);
        end
        s_tvalid = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("abort_reset", 128'({wr_finish, busy, s_tready, wr_enable}), 128'(4'b1000));
        #1 rst = 1'b0;
        @(posedge clk); #1;
        fresh = '{0, 1'b0, -1, 1'b0, 1'b0, 32'h0, 1'b0};
        run_poly(fresh);

        // Two back-to-back polynomials into the depth-4 FIFO model.
        ptr0 = wr_ptr;
        b2b0 = '{0, 1'b0, -1, 1'b0, 1'b0, 32'h400, 1'b0};
        b2b1 = '{0, 1'b1, -1, 1'b0, 1'b0, 32'h500, 1'b0};
        run_poly(b2b0);
        run_poly(b2b1);
        check("wr_pointer_advance", 128'(wr_ptr - ptr0), 128'(2));
        for (int a = 0; a < PL; a++) begin
            check("readback_poly0", 128'(fifo_mem[ptr0 % 4][a]), 128'(32'h400 + a));
            check("readback_poly1", 128'(fifo_mem[(ptr0 + 1) % 4][a]), 128'(32'h500 + a));
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
